// File: rtl/safety_island_pkg.sv
// Shared types and register map for the safety island boot controller.
package safety_island_pkg;

  typedef enum logic [1:0] {
    BOOT_JTAG      = 2'b00,
    BOOT_PRELOADED = 2'b01
  } bootmode_e;

  localparam logic [11:0] REG_BOOT_ADDR   = 12'h000;
  localparam logic [11:0] REG_START       = 12'h004;
  localparam logic [11:0] REG_CORE_STATUS = 12'h008;
  localparam logic [11:0] REG_BOOTMODE    = 12'h00C;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_START,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } boot_state_e;

endpackage

// File: rtl/safety_island_boot_ctrl_if.sv
// Register bus bundle: request from master, single-cycle-latency response.
interface safety_island_boot_ctrl_if;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/safety_island_boot_ctrl.sv
// Safety island boot controller: register file plus boot sequencing FSM.
module safety_island_boot_ctrl
  import safety_island_pkg::*;
#(
  parameter logic [31:0] BaseAddr        = 32'h6000_0000,
  parameter logic [31:0] BootRomOffset   = 32'h0000_1000,
  parameter int unsigned ResetHoldCycles = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  bootmode_i,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [11:0] reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        reg_gnt_o,
  output logic        reg_rvalid_o,
  output logic [31:0] reg_rdata_o,
  output logic        reg_err_o,
  output logic        core_rst_no,
  output logic        fetch_en_o,
  output logic [31:0] boot_addr_o,
  output logic        eoc_o,
  output logic [30:0] exit_code_o,
  output logic        boot_err_o
);

  // Sum wraps modulo 2^32 by construction of the 32-bit result.
  localparam logic [31:0] JtagAddr = BaseAddr + BootRomOffset;
  localparam logic [7:0]  HoldLast = 8'(ResetHoldCycles - 1);

  boot_state_e state_q, state_d;
  logic [7:0]  hold_cnt_q;
  logic [1:0]  bootmode_q;
  logic [31:0] boot_addr_reg_q, boot_addr_q, core_status_q;
  logic        start_pending_q;
  logic        rvalid_q, err_q;
  logic [31:0] rdata_q;

  logic        mapped, wr, rd, hold_last, run_entry;
  logic [31:0] rd_mux;

  assign reg_gnt_o    = reg_req_i;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign reg_err_o    = err_q;
  assign boot_addr_o  = boot_addr_q;
  assign eoc_o        = core_status_q[31];
  assign exit_code_o  = core_status_q[30:0];

  // Address decode and read mux; misaligned offsets simply never match.
  always_comb begin
    mapped = 1'b1;
    rd_mux = '0;
    case (reg_addr_i)
      REG_BOOT_ADDR:   rd_mux = boot_addr_reg_q;
      REG_START:       rd_mux = {31'b0, start_pending_q};
      REG_CORE_STATUS: rd_mux = core_status_q;
      REG_BOOTMODE:    rd_mux = {30'b0, bootmode_q};
      default:         mapped = 1'b0;
    endcase
    wr = reg_req_i && reg_we_i && mapped;
    rd = reg_req_i && !reg_we_i && mapped;
  end

  // Next-state and core control outputs.
  always_comb begin
    state_d     = state_q;
    core_rst_no = 1'b0;
    fetch_en_o  = 1'b0;
    boot_err_o  = 1'b0;
    hold_last   = (hold_cnt_q == HoldLast);
    case (state_q)
      ST_HOLD: begin
        if (hold_last) begin
          case (bootmode_e'(bootmode_i))
            BOOT_JTAG:      state_d = ST_RUN;
            BOOT_PRELOADED: state_d = ST_WAIT_START;
            default:        state_d = ST_ERR;
          endcase
        end
      end
      ST_WAIT_START: begin
        core_rst_no = 1'b1;
        if (start_pending_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        core_rst_no = 1'b1;
        fetch_en_o  = 1'b1;
        if (core_status_q[31]) state_d = ST_DONE;
      end
      ST_DONE: begin
        core_rst_no = 1'b1;
        fetch_en_o  = 1'b1;
      end
      default: boot_err_o = 1'b1;
    endcase
    run_entry = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  // State, register file and response pipeline; register writes land after
  // the FSM's own updates so a coinciding write always takes effect.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= ST_HOLD;
      hold_cnt_q      <= '0;
      bootmode_q      <= '0;
      boot_addr_reg_q <= BaseAddr;
      boot_addr_q     <= BaseAddr;
      core_status_q   <= '0;
      start_pending_q <= 1'b0;
      rvalid_q        <= 1'b0;
      rdata_q         <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_HOLD && !hold_last) hold_cnt_q <= hold_cnt_q + 8'd1;
      if (state_q == ST_HOLD && hold_last)  bootmode_q <= bootmode_i;
      if (run_entry) begin
        // Only the Jtag path goes straight from HOLD to RUN.
        boot_addr_q     <= (state_q == ST_HOLD) ? JtagAddr : boot_addr_reg_q;
        start_pending_q <= 1'b0;
      end
      if (wr) begin
        case (reg_addr_i)
          REG_BOOT_ADDR:   boot_addr_reg_q <= reg_wdata_i;
          REG_START:       if (reg_wdata_i[0]) start_pending_q <= 1'b1;
          REG_CORE_STATUS: core_status_q <= reg_wdata_i;
          default: ;
        endcase
      end
      rvalid_q <= reg_req_i;
      rdata_q  <= rd ? rd_mux : '0;
      err_q    <= reg_req_i && !mapped;
    end
  end

endmodule

// File: tb/tb_safety_island_boot_ctrl.sv
// Directed bench for the safety island boot controller.
module tb_safety_island_boot_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  bootmode = 2'b00;
  logic        core_rst_n, fetch_en, eoc, boot_err;
  logic [31:0] boot_addr;
  logic [30:0] exit_code;
  int          n_chk = 0;
  int          n_err = 0;

  safety_island_boot_ctrl_if bus ();

  safety_island_boot_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bootmode_i  (bootmode),
    .reg_req_i   (bus.req),
    .reg_we_i    (bus.we),
    .reg_addr_i  (bus.addr),
    .reg_wdata_i (bus.wdata),
    .reg_gnt_o   (bus.gnt),
    .reg_rvalid_o(bus.rvalid),
    .reg_rdata_o (bus.rdata),
    .reg_err_o   (bus.err),
    .core_rst_no (core_rst_n),
    .fetch_en_o  (fetch_en),
    .boot_addr_o (boot_addr),
    .eoc_o       (eoc),
    .exit_code_o (exit_code),
    .boot_err_o  (boot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One register access; returns the response sampled in the rvalid cycle.
  task automatic reg_acc(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err);
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    #1;
    chk("gnt", {31'b0, bus.gnt}, 32'd1);
    tick();
    bus.req = 1'b0; bus.we = 1'b0;
    chk("rvalid", {31'b0, bus.rvalid}, 32'd1);
    rdata = bus.rdata;
    err   = bus.err;
  endtask

  task automatic do_reset(input logic [1:0] mode);
    bootmode = mode;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  logic [31:0] rd;
  logic        er;
  logic        saw_fetch;

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset values
    do_reset(2'b00);
    chk("rst core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("rst fetch_en", {31'b0, fetch_en}, 32'd0);
    chk("rst boot_addr", boot_addr, 32'h6000_0000);
    chk("rst eoc", {31'b0, eoc}, 32'd0);
    chk("rst exit_code", {1'b0, exit_code}, 32'd0);
    chk("rst boot_err", {31'b0, boot_err}, 32'd0);
    chk("rst rvalid", {31'b0, bus.rvalid}, 32'd0);

    // Jtag boot: 8 hold cycles then straight into RUN
    tick(7);
    chk("jtag hold core_rst_n", {31'b0, core_rst_n}, 32'd0);
    tick();
    chk("jtag core_rst_n", {31'b0, core_rst_n}, 32'd1);
    chk("jtag fetch_en", {31'b0, fetch_en}, 32'd1);
    chk("jtag boot_addr", boot_addr, 32'h6000_1000);

    // End of computation
    reg_acc(1'b1, 12'h008, 32'h8000_002A, rd, er);
    chk("eoc wr rdata", rd, 32'd0);
    chk("eoc wr err", {31'b0, er}, 32'd0);
    chk("eoc", {31'b0, eoc}, 32'd1);
    chk("exit_code", {1'b0, exit_code}, 32'd42);
    tick();
    chk("done fetch_en", {31'b0, fetch_en}, 32'd1);
    reg_acc(1'b1, 12'h000, 32'h1234_5678, rd, er);
    tick();
    chk("done boot_addr kept", boot_addr, 32'h6000_1000);
    reg_acc(1'b0, 12'h000, 32'h0, rd, er);
    chk("boot_addr reg rd", rd, 32'h1234_5678);

    // Illegal accesses
    reg_acc(1'b0, 12'h010, 32'h0, rd, er);
    chk("unmapped err", {31'b0, er}, 32'd1);
    chk("unmapped rdata", rd, 32'd0);
    reg_acc(1'b1, 12'h002, 32'h0000_0000, rd, er);
    chk("misaligned err", {31'b0, er}, 32'd1);
    reg_acc(1'b0, 12'h008, 32'h0, rd, er);
    chk("status intact", rd, 32'h8000_002A);
    chk("done after illegal", {31'b0, fetch_en}, 32'd1);

    // Reset mid-DONE with a request in flight
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 12'h000;
    rst_n = 1'b0;
    tick();
    bus.req = 1'b0;
    chk("mid rst fetch_en", {31'b0, fetch_en}, 32'd0);
    chk("mid rst core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("mid rst rvalid", {31'b0, bus.rvalid}, 32'd0);
    chk("mid rst eoc", {31'b0, eoc}, 32'd0);

    // Preloaded boot
    do_reset(2'b01);
    tick(8);
    chk("pre wait core_rst_n", {31'b0, core_rst_n}, 32'd1);
    chk("pre wait fetch_en", {31'b0, fetch_en}, 32'd0);
    reg_acc(1'b1, 12'h000, 32'h6001_0080, rd, er);
    reg_acc(1'b1, 12'h004, 32'h1, rd, er);
    chk("pre start seen fetch_en", {31'b0, fetch_en}, 32'd0);
    tick();
    chk("pre run fetch_en", {31'b0, fetch_en}, 32'd1);
    chk("pre boot_addr", boot_addr, 32'h6001_0080);
    reg_acc(1'b0, 12'h004, 32'h0, rd, er);
    chk("pre start cleared", rd, 32'd0);
    reg_acc(1'b0, 12'h00C, 32'h0, rd, er);
    chk("pre bootmode rd", rd, 32'd1);

    // Early start during HOLD
    do_reset(2'b01);
    reg_acc(1'b1, 12'h004, 32'h1, rd, er);
    tick(6);
    chk("early hold", {31'b0, core_rst_n}, 32'd0);
    tick();
    chk("early wait core_rst_n", {31'b0, core_rst_n}, 32'd1);
    chk("early wait fetch_en", {31'b0, fetch_en}, 32'd0);
    tick();
    chk("early run fetch_en", {31'b0, fetch_en}, 32'd1);
    chk("early boot_addr", boot_addr, 32'h6000_0000);

    // Reserved boot mode
    do_reset(2'b10);
    tick(8);
    chk("rsv boot_err", {31'b0, boot_err}, 32'd1);
    chk("rsv core_rst_n", {31'b0, core_rst_n}, 32'd0);
    bootmode = 2'b00;
    saw_fetch = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fetch_en) saw_fetch = 1'b1;
    end
    chk("rsv fetch never", {31'b0, saw_fetch}, 32'd0);
    reg_acc(1'b1, 12'h00C, 32'h0, rd, er);
    chk("rsv bootmode wr err", {31'b0, er}, 32'd0);
    reg_acc(1'b0, 12'h00C, 32'h0, rd, er);
    chk("rsv bootmode rd", rd, 32'd2);
    chk("rsv boot_err kept", {31'b0, boot_err}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
